spi_slave_regif: RTL and testbench

- SPI mode-0 slave. It terminates the host SPI link at the FourierTransform top and converts each SPI frame into a single-cycle register-bus read or write toward the register file (FREQ_n, EN_CORDIC, STATUS, DATA_n).
- SCK, SS_N and MOSI are oversampled in the clk domain. No logic runs on the SCK clock.
- Each frame is one command byte followed by one data word. The block also reports per-frame status for debug.

---
 rtl/spi_slave_regif.sv | 197 +++++++++++++++++++
 tb/tb_spi_slave_regif.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_regif.sv
// SPI mode-0 slave that turns each {rw, addr, data} frame into one register-bus access.
// SCK/SS_N/MOSI are oversampled in the clk domain; all logic runs on clk.
module spi_slave_regif #(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              spi_sck,
  input  logic              spi_ss_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [DATA_W-1:0] reg_rdata,
  output logic              frame_err,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned CmdBits   = ADDR_W + 1;
  localparam int unsigned FrameBits = CmdBits + DATA_W;
  localparam int unsigned CntW      = $clog2(FrameBits + 1);
  localparam logic [CntW-1:0] CmdLast   = CntW'(CmdBits - 1);
  localparam logic [CntW-1:0] FrameLast = CntW'(FrameBits - 1);

  typedef enum logic [2:0] {StIdle, StCmd, StRdLoad, StData, StDone} state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic                   sck_s, ss_s, mosi_s;
  logic                   sck_rise, sck_fall, ss_fall;

  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [ADDR_W-1:0] cmd_q, cmd_d;
  logic [DATA_W-2:0] rx_q, rx_d;
  logic [DATA_W-1:0] tx_q, tx_d;
  logic              rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cmd_next;
  logic [DATA_W-1:0] rx_next;

  logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              miso_q, miso_d;
  logic              frame_err_q, frame_err_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign ss_s     = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign ss_fall  = ~ss_s & ss_prev_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    cmd_d       = cmd_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = 1'b0;
    reg_re_d    = 1'b0;
    miso_d      = miso_q;
    frame_err_d = frame_err_q;
    frame_cnt_d = frame_cnt_q;
    cmd_next    = {cmd_q, mosi_s};
    rx_next     = {rx_q, mosi_s};

    if (ss_s && (state_q inside {StCmd, StRdLoad, StData})) begin
      // Master deselected before the last bit: drop the frame, never write.
      state_d     = StIdle;
      frame_err_d = 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          miso_d = 1'b0;
          if (ss_fall) begin
            state_d   = StCmd;
            bit_cnt_d = '0;
          end
        end
        StCmd: begin
          if (sck_rise) begin
            cmd_d     = cmd_next[ADDR_W-1:0];
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (bit_cnt_q == CmdLast) begin
              rw_d       = cmd_next[ADDR_W];
              addr_d     = cmd_next[ADDR_W-1:0];
              reg_addr_d = cmd_next[ADDR_W-1:0];
              if (cmd_next[ADDR_W]) begin
                state_d = StData;
              end else begin
                reg_re_d = 1'b1;
                state_d  = StRdLoad;
              end
            end
          end
        end
        StRdLoad: begin
          // reg_re is high on the first cycle here; read data is valid on the next one.
          if (!reg_re_q) begin
            tx_d    = reg_rdata;
            state_d = StData;
          end
        end
        StData: begin
          if (sck_fall && !rw_q) begin
            miso_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
          end
          if (sck_rise) begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
            if (rw_q) rx_d = rx_next[DATA_W-2:0];
            if (bit_cnt_q == FrameLast) begin
              state_d     = StDone;
              reg_we_d    = rw_q;
              reg_addr_d  = addr_q;
              if (rw_q) reg_wdata_d = rx_next;
              frame_cnt_d = frame_cnt_q + 16'd1;
              frame_err_d = 1'b0;
            end
          end
        end
        StDone: begin
          if (ss_s) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end

    if (ss_s) miso_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q     <= StIdle;
      sck_sync_q  <= '0;
      ss_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      cmd_q       <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      rw_q        <= 1'b0;
      addr_q      <= '0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      miso_q      <= 1'b0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_s;
      bit_cnt_q   <= bit_cnt_d;
      cmd_q       <= cmd_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_re_q    <= reg_re_d;
      miso_q      <= miso_d;
      frame_err_q <= frame_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign spi_miso  = miso_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_spi_slave_regif.sv
// Randomised/directed bench for spi_slave_regif: a bit-banged SPI master, a register-file model,
// and a strobe scoreboard checked by an independent monitor.
`timescale 1ns/1ps
module tb_spi_slave_regif;

  localparam int Half = 50;  // SCK half period in ns

  logic        clk = 1'b0;
  logic        rstn;
  logic        spi_sck, spi_ss_n, spi_mosi, spi_miso;
  logic [6:0]  reg_addr;
  logic [31:0] reg_wdata, reg_rdata;
  logic        reg_we, reg_re, frame_err;
  logic [15:0] frame_cnt;

  spi_slave_regif #(.ADDR_W(7), .DATA_W(32), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .spi_sck   (spi_sck),
    .spi_ss_n  (spi_ss_n),
    .spi_mosi  (spi_mosi),
    .spi_miso  (spi_miso),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #2.5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [6:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] mem [128];
  int          checks = 0;
  int          failures = 0;
  logic [15:0] model_cnt = '0;
  logic        model_err = 1'b0;

  // Register file: read data appears one clk after reg_re.
  always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Strobe monitor: every reg_we/reg_re pulse must match the next queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && (reg_we || reg_re)) begin
        check("strobe_exclusive", {reg_we, reg_re}, {reg_we, ~reg_we});
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", {reg_we, reg_re}, 2'b00);
        end else begin
          e = exp_q.pop_front();
          check("strobe_kind_we", reg_we, e.we);
          check("strobe_addr", reg_addr, e.addr);
          if (e.we) check("strobe_wdata", reg_wdata, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    check("rst_miso", spi_miso, 0);
    check("rst_we", reg_we, 0);
    check("rst_re", reg_re, 0);
    check("rst_addr", reg_addr, 0);
    check("rst_wdata", reg_wdata, 0);
    check("rst_err", frame_err, 0);
    check("rst_cnt", frame_cnt, 0);
    repeat (2) @(negedge clk);
    rstn      = 1'b1;
    model_cnt = '0;
    model_err = 1'b0;
  endtask

  // One SPI frame from the master; stop_at cuts the frame after that many bits,
  // rst_at pulses reset while SCK is high during that bit.
  task automatic spi_frame(input logic rw, input logic [6:0] addr, input logic [31:0] data,
                           input int stop_at, input int rst_at, input int extra,
                           output logic [31:0] rd);
    logic [39:0] fr;
    fr = {rw, addr, data};
    rd = '0;
    @(negedge clk);
    spi_ss_n = 1'b0;
    spi_mosi = fr[39];
    #(Half);
    for (int i = 0; i < 40; i++) begin
      if (i == stop_at) break;
      spi_sck = 1'b1;
      if (i >= 8) rd = {rd[30:0], spi_miso};
      if (i == rst_at) begin
        do_reset();
        break;
      end
      #(Half);
      spi_sck = 1'b0;
      if (i < 39) spi_mosi = fr[38-i];
      #(Half);
    end
    spi_sck = 1'b0;
    for (int k = 0; k < extra; k++) begin
      #(Half) spi_sck = 1'b1;
      #(Half) spi_sck = 1'b0;
    end
    #(Half);
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    #(4 * Half);
  endtask

  task automatic run_frame(input logic rw, input logic [6:0] addr, input logic [31:0] data,
                           input int stop_at, input int rst_at, input int extra);
    logic [31:0] rd;
    logic        complete;
    complete = (stop_at < 0) && (rst_at < 0);
    if (complete) exp_q.push_back('{we: rw, addr: addr, data: rw ? data : 32'h0});
    spi_frame(rw, addr, data, stop_at, rst_at, extra, rd);
    if (complete) begin
      model_cnt = model_cnt + 16'd1;
      model_err = 1'b0;
      if (!rw) check("miso_word", rd, mem[addr]);
    end else if (rst_at < 0) begin
      model_err = 1'b1;
    end
    check("idle_miso", spi_miso, 0);
    check("frame_cnt", frame_cnt, model_cnt);
    check("frame_err", frame_err, model_err);
  endtask

  initial begin
    int vals [11] = '{1000, 1500, 2000, 3000, 4000, 5000, 6000, 7000, 8000, 9000, 10000};
    logic        rw;
    logic [6:0]  a;
    logic [31:0] d;
    rstn = 1'b1;
    spi_sck = 1'b0;
    spi_ss_n = 1'b1;
    spi_mosi = 1'b0;
    reg_rdata = '0;
    for (int i = 0; i < 128; i++) mem[i] = $urandom;
    mem[2] = 32'h3202_4003;

    do_reset();
    repeat (5) @(negedge clk);

    run_frame(1'b1, 7'h01, 32'd1000, -1, -1, 0);
    run_frame(1'b0, 7'h02, 32'h0, -1, -1, 0);
    run_frame(1'b1, 7'h05, 32'hDEAD_BEEF, 20, -1, 0);
    run_frame(1'b1, 7'h03, 32'd2000, -1, -1, 0);
    run_frame(1'b1, 7'h04, 32'h1234_5678, -1, 25, 0);
    run_frame(1'b1, 7'h0B, 32'd10000, -1, -1, 0);

    do_reset();
    for (int i = 0; i < 11; i++) run_frame(1'b1, 7'(i + 1), vals[i], -1, -1, 0);
    check("b2b_count", frame_cnt, 16'd11);

    run_frame(1'b0, 7'h02, 32'h0, -1, -1, 8);

    for (int n = 0; n < 8; n++) begin
      rw = 1'($urandom_range(0, 1));
      a  = 7'($urandom);
      d  = $urandom;
      run_frame(rw, a, d, -1, -1, 0);
    end

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
